d_stage_pipelined: RTL and testbench
====================================

Name: d_stage_pipelined

Overview:
- Parametrised decode stage for the RISC-V pipeline, sitting between fetch and ALU.
- Decodes RV32I integer ops: R/I ALU, loads, stores, branches, JAL, LUI.
- Holds an internal register file and a valid/ready output register.
- Adds over the previous decode stage:
  - WB-to-read bypass.
  - Load-use hazard bubbles.
  - Branch flush.
  - Illegal-opcode flag.
  - Full-width target PC.
  - Saturating stall counter.

Parameters:
- XLEN, 32: datapath, PC and immediate width.
- NREGS, 32: architectural registers. Power of two, ≤ 32. RAW = log2(NREGS).
- CNT_W, 16: stall counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- fd_valid  in  1  fetch presents an instruction.
- fd_ready  out  1  decode accepts this cycle (combinational).
- fd_pc  in  XLEN  instruction PC.
- fd_instr  in  32  instruction word.
- flush  in  1  branch redirect: kill held and incoming instruction.
- w_regfile  in  1  WB write enable.
- sel_regfile  in  RAW  WB destination.
- data_regfile  in  XLEN  WB data.
- a_ready  in  1  ALU accepts output register.
- da_valid  out  1  output register holds a live instruction.
- da_pc  out  XLEN  PC.
- da_write_sel, da_read_sel1, da_read_sel2  out  RAW  rd, rs1, rs2.
- da_data1, da_data2  out  XLEN  operands.
- da_imm32  out  XLEN  sign-extended immediate.
- da_ALU_Control  out  6  operation code.
- da_target_PC  out  XLEN  branch/JAL target.
- da_is_wb, da_is_branch, da_is_jump, da_is_load, da_is_store, da_illegal  out  1 each  class flags.
- d_stall_count  out  CNT_W  load-use bubbles inserted.

Behaviour:
- Reset (reset=0, asynchronous):
  - Every da_* output and d_stall_count go to 0.
  - Register file is cleared.
  - fd_ready is combinational from state, so it reads 1 after reset.
- advance = !da_valid || a_ready.
- hazard:
  - Asserted when da_valid && da_is_load && da_write_sel!=0.
  - And da_write_sel equals the incoming instruction's rs1 (if used) or rs2 (if used: R-type, store, branch).
- fd_ready = advance && (!hazard || flush).
- Clock edge priority:
  1. flush: da_valid<=0. Any incoming instruction is discarded.
  2. advance && hazard: bubble. da_valid<=0, d_stall_count += 1, saturating at all-ones.
  3. advance && fd_valid: load every da_* from decode, da_valid<=1.
  4. advance && !fd_valid: da_valid<=0.
  5. Otherwise hold every da_* unchanged (ALU stalled).
- Latency: one cycle from acceptance to da_valid.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Same-cycle WB write to a nonzero matching read select bypasses data_regfile onto the operand.
  - WB writes proceed regardless of stall or flush.
- Immediates:
  - I-type and load: instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - SB-type: {31, 7, 30:25, 11:8, 0}.
  - UJ-type: {31, 19:12, 20, 30:21, 0}.
  - U-type: {31:12, 12'b0}.
  - All sign-extended to XLEN.
- da_target_PC = fd_pc + imm, full XLEN, modulo 2^XLEN, for branch and JAL; 0 otherwise.
- ALU_Control, R-type and OP-IMM:
  - add 000000, sub 000001 (R-type, funct7[5]=1).
  - and 000010, or 000011, xor 000100.
  - sll 000101, srl 000110, sra 000111.
  - slt 001000, sltu 001001.
- ALU_Control, other classes:
  - Branches: beq 010000, bne 010001, blt 010100, bge 010101, bltu 010110, bgeu 010111.
  - Load and store: 000000.
  - LUI: 100000. JAL: 100001.
- da_is_wb: set for R-type, OP-IMM, load, LUI, JAL; forced to 0 when rd=0.
- Illegal:
  - Triggers: unknown opcode, or branch funct3 of 010/011.
  - Sets da_illegal=1 with all other class flags 0 and ALU_Control 0.
  - Still handshakes normally.

Test Plan:
- Reset, then fd_valid=1, addi x5,x0,-3 (0xFFD00293), pc=0x100 -> next cycle da_valid=1, da_imm32=0xFFFFFFFD, da_write_sel=5, da_is_wb=1, ALU_Control 000000.
- lw x6,0(x1), then add x7,x6,x2 with a_ready=1 -> add held one cycle (fd_ready=0), bubble da_valid=0, d_stall_count=1, add issued the following cycle.
- WB writes x3=0xDEADBEEF in the same cycle add x4,x3,x3 is accepted -> da_data1=da_data2=0xDEADBEEF.
- beq at pc=0xFFFFFFF0 with offset +0x20 -> da_target_PC=0x00000010 (wrap), ALU_Control 010000.
- a_ready=0 for 3 cycles with da_valid=1 -> all da_* stable, fd_ready=0. Assert flush -> da_valid=0 next cycle.
- Opcode 0x7F -> da_illegal=1, da_is_wb=0. Assert reset mid-stall -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/d_stage_pipelined.sv
// RV32I decode stage: regfile with WB bypass, load-use bubbles, flush,
// illegal-op flag and a registered valid/ready output slot toward the ALU.
module d_stage_pipelined #(
   parameter int  XLEN  = 32,
   parameter int  NREGS = 32,
   parameter int  CNT_W = 16,
   localparam int RAW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            fd_valid,
   output logic            fd_ready,
   input  logic [XLEN-1:0] fd_pc,
   input  logic [31:0]     fd_instr,
   input  logic            flush,
   input  logic            w_regfile,
   input  logic [RAW-1:0]  sel_regfile,
   input  logic [XLEN-1:0] data_regfile,
   input  logic            a_ready,
   output logic            da_valid,
   output logic [XLEN-1:0] da_pc,
   output logic [RAW-1:0]  da_write_sel,
   output logic [RAW-1:0]  da_read_sel1,
   output logic [RAW-1:0]  da_read_sel2,
   output logic [XLEN-1:0] da_data1,
   output logic [XLEN-1:0] da_data2,
   output logic [XLEN-1:0] da_imm32,
   output logic [5:0]      da_ALU_Control,
   output logic [XLEN-1:0] da_target_PC,
   output logic            da_is_wb,
   output logic            da_is_branch,
   output logic            da_is_jump,
   output logic            da_is_load,
   output logic            da_is_store,
   output logic            da_illegal,
   output logic [CNT_W-1:0] d_stall_count
);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [RAW-1:0]  wsel, rsel1, rsel2;
      logic [XLEN-1:0] data1, data2, imm, tgt;
      logic [5:0]      alu;
      logic            wb, br, jmp, ld, st, ill;
   } da_t;

   da_t              da_q, da_d, dec;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];

   logic [6:0]        opc;
   logic [2:0]        f3;
   logic              f7b, use1, use2, advance, hazard;
   logic [RAW-1:0]    rs1_sel, rs2_sel, rd_sel;
   logic signed [31:0] imm32;

   assign opc     = fd_instr[6:0];
   assign f3      = fd_instr[14:12];
   assign f7b     = fd_instr[30];
   assign rd_sel  = fd_instr[7 +: RAW];
   assign rs1_sel = fd_instr[15 +: RAW];
   assign rs2_sel = fd_instr[20 +: RAW];

   // alt selects sub/sra; the caller masks it for OP-IMM add
   function automatic logic [5:0] alu_op(input logic [2:0] fn, input logic alt);
      case (fn)
         3'b000:  alu_op = {5'b0, alt};
         3'b001:  alu_op = 6'd5;
         3'b010:  alu_op = 6'd8;
         3'b011:  alu_op = 6'd9;
         3'b100:  alu_op = 6'd4;
         3'b101:  alu_op = alt ? 6'd7 : 6'd6;
         3'b110:  alu_op = 6'd3;
         default: alu_op = 6'd2;
      endcase
   endfunction

   always_comb begin
      dec       = '0;
      imm32     = '0;
      use1      = 1'b0;
      use2      = 1'b0;
      dec.valid = 1'b1;
      dec.pc    = fd_pc;
      dec.wsel  = rd_sel;
      dec.rsel1 = rs1_sel;
      dec.rsel2 = rs2_sel;
      case (opc)
         OP_R: begin
            use1 = 1'b1; use2 = 1'b1; dec.wb = 1'b1;
            dec.alu = alu_op(f3, f7b);
         end
         OP_I: begin
            use1 = 1'b1; dec.wb = 1'b1;
            dec.alu = alu_op(f3, f7b && (f3 == 3'b101));
            imm32 = {{20{fd_instr[31]}}, fd_instr[31:20]};
         end
         OP_LD: begin
            use1 = 1'b1; dec.wb = 1'b1; dec.ld = 1'b1;
            imm32 = {{20{fd_instr[31]}}, fd_instr[31:20]};
         end
         OP_ST: begin
            use1 = 1'b1; use2 = 1'b1; dec.st = 1'b1;
            imm32 = {{20{fd_instr[31]}}, fd_instr[31:25], fd_instr[11:7]};
         end
         OP_BR: begin
            if (f3[2:1] == 2'b01) begin
               dec.ill = 1'b1;
            end else begin
               use1 = 1'b1; use2 = 1'b1; dec.br = 1'b1;
               dec.alu = {3'b010, f3};
               imm32 = {{20{fd_instr[31]}}, fd_instr[7], fd_instr[30:25],
                        fd_instr[11:8], 1'b0};
            end
         end
         OP_JAL: begin
            dec.wb = 1'b1; dec.jmp = 1'b1; dec.alu = 6'b100001;
            imm32 = {{12{fd_instr[31]}}, fd_instr[19:12], fd_instr[20],
                     fd_instr[30:21], 1'b0};
         end
         OP_LUI: begin
            dec.wb = 1'b1; dec.alu = 6'b100000;
            imm32 = {fd_instr[31:12], 12'b0};
         end
         default: dec.ill = 1'b1;
      endcase
      if (rd_sel == '0) dec.wb = 1'b0;
      dec.imm = XLEN'(imm32);
      dec.tgt = (dec.br || dec.jmp) ? fd_pc + dec.imm : '0;
      // operand read with same-cycle WB bypass; x0 is hardwired zero
      dec.data1 = (w_regfile && sel_regfile != '0 && sel_regfile == rs1_sel)
                  ? data_regfile : regs_q[rs1_sel];
      dec.data2 = (w_regfile && sel_regfile != '0 && sel_regfile == rs2_sel)
                  ? data_regfile : regs_q[rs2_sel];
      if (rs1_sel == '0) dec.data1 = '0;
      if (rs2_sel == '0) dec.data2 = '0;
   end

   assign advance  = !da_q.valid || a_ready;
   assign hazard   = fd_valid && da_q.valid && da_q.ld && (da_q.wsel != '0) &&
                     ((use1 && rs1_sel == da_q.wsel) || (use2 && rs2_sel == da_q.wsel));
   assign fd_ready = advance && (!hazard || flush);

   always_comb begin
      da_d  = da_q;
      cnt_d = cnt_q;
      if (flush) begin
         da_d.valid = 1'b0;
      end else if (advance && hazard) begin
         da_d.valid = 1'b0;
         if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else if (advance && fd_valid) begin
         da_d = dec;
      end else if (advance) begin
         da_d.valid = 1'b0;
      end
   end

   always_comb begin
      regs_d = regs_q;
      if (w_regfile && sel_regfile != '0) regs_d[sel_regfile] = data_regfile;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         da_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         da_q   <= da_d;
         cnt_q  <= cnt_d;
         regs_q <= regs_d;
      end
   end

   assign da_valid       = da_q.valid;
   assign da_pc          = da_q.pc;
   assign da_write_sel   = da_q.wsel;
   assign da_read_sel1   = da_q.rsel1;
   assign da_read_sel2   = da_q.rsel2;
   assign da_data1       = da_q.data1;
   assign da_data2       = da_q.data2;
   assign da_imm32       = da_q.imm;
   assign da_ALU_Control = da_q.alu;
   assign da_target_PC   = da_q.tgt;
   assign da_is_wb       = da_q.wb;
   assign da_is_branch   = da_q.br;
   assign da_is_jump     = da_q.jmp;
   assign da_is_load     = da_q.ld;
   assign da_is_store    = da_q.st;
   assign da_illegal     = da_q.ill;
   assign d_stall_count  = cnt_q;

endmodule

// File: tb/tb_d_stage_pipelined.sv
// Decode-stage bench: directed scenarios plus random traffic against a
// cycle-level reference model of the decode/handshake rules.
module tb_d_stage_pipelined;

   logic        clock = 1'b0, reset = 1'b0;
   logic        fd_valid = 1'b0, fd_ready, flush = 1'b0, w_regfile = 1'b0, a_ready = 1'b0;
   logic [31:0] fd_pc = '0, fd_instr = '0, data_regfile = '0;
   logic [4:0]  sel_regfile = '0;
   logic        da_valid, da_is_wb, da_is_branch, da_is_jump, da_is_load, da_is_store, da_illegal;
   logic [31:0] da_pc, da_data1, da_data2, da_imm32, da_target_PC;
   logic [4:0]  da_write_sel, da_read_sel1, da_read_sel2;
   logic [5:0]  da_ALU_Control;
   logic [15:0] d_stall_count;

   d_stage_pipelined dut (
      .clock(clock), .reset(reset), .fd_valid(fd_valid), .fd_ready(fd_ready),
      .fd_pc(fd_pc), .fd_instr(fd_instr), .flush(flush), .w_regfile(w_regfile),
      .sel_regfile(sel_regfile), .data_regfile(data_regfile), .a_ready(a_ready),
      .da_valid(da_valid), .da_pc(da_pc), .da_write_sel(da_write_sel),
      .da_read_sel1(da_read_sel1), .da_read_sel2(da_read_sel2),
      .da_data1(da_data1), .da_data2(da_data2), .da_imm32(da_imm32),
      .da_ALU_Control(da_ALU_Control), .da_target_PC(da_target_PC),
      .da_is_wb(da_is_wb), .da_is_branch(da_is_branch), .da_is_jump(da_is_jump),
      .da_is_load(da_is_load), .da_is_store(da_is_store), .da_illegal(da_illegal),
      .d_stall_count(d_stall_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  wsel, rs1, rs2;
      logic [31:0] d1, d2, imm, tgt;
      logic [5:0]  alu;
      logic        wb, br, jmp, ld, st, ill;
   } exp_t;

   exp_t        m;
   logic [15:0] m_cnt;
   logic [31:0] regs [32];
   int          n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                    output logic u1, output logic u2);
      exp_t       e;
      logic [2:0] f3;
      int         base [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
      e = '0; u1 = 1'b0; u2 = 1'b0;
      e.valid = 1'b1; e.pc = pc;
      e.wsel = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
      f3 = ins[14:12];
      case (ins[6:0])
         7'h33: begin
            u1 = 1; u2 = 1; e.wb = 1; e.alu = 6'(base[f3]);
            if (ins[30] && (f3 == 0 || f3 == 5)) e.alu = e.alu + 1;
         end
         7'h13: begin
            u1 = 1; e.wb = 1; e.alu = 6'(base[f3]);
            if (ins[30] && f3 == 5) e.alu = e.alu + 1;
            e.imm = 32'($signed(ins[31:20]));
         end
         7'h03: begin u1 = 1; e.wb = 1; e.ld = 1; e.imm = 32'($signed(ins[31:20])); end
         7'h23: begin
            u1 = 1; u2 = 1; e.st = 1;
            e.imm = 32'($signed({ins[31:25], ins[11:7]}));
         end
         7'h63: begin
            if (f3 == 2 || f3 == 3) e.ill = 1;
            else begin
               u1 = 1; u2 = 1; e.br = 1; e.alu = 6'h10 + 6'(f3);
               e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
               e.tgt = pc + e.imm;
            end
         end
         7'h6F: begin
            e.wb = 1; e.jmp = 1; e.alu = 6'h21;
            e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            e.tgt = pc + e.imm;
         end
         7'h37: begin e.wb = 1; e.alu = 6'h20; e.imm = {ins[31:12], 12'h000}; end
         default: e.ill = 1;
      endcase
      if (e.wsel == 0) e.wb = 0;
      return e;
   endfunction

   function automatic logic [31:0] rdreg(input logic [4:0] s);
      if (s == 0) return 32'h0;
      if (w_regfile && sel_regfile == s) return data_regfile;
      return regs[s];
   endfunction

   task automatic model_reset();
      m = '0; m_cnt = '0;
      for (int i = 0; i < 32; i++) regs[i] = '0;
   endtask

   task automatic check_outputs();
      chk("da_valid", da_valid, m.valid);
      chk("stall_count", d_stall_count, m_cnt);
      if (m.valid) begin
         chk("da_pc", da_pc, m.pc);
         chk("write_sel", da_write_sel, m.wsel);
         chk("read_sel1", da_read_sel1, m.rs1);
         chk("read_sel2", da_read_sel2, m.rs2);
         chk("data1", da_data1, m.d1);
         chk("data2", da_data2, m.d2);
         chk("imm32", da_imm32, m.imm);
         chk("alu_ctl", da_ALU_Control, m.alu);
         chk("target_pc", da_target_PC, m.tgt);
         chk("flags", {da_is_wb, da_is_branch, da_is_jump, da_is_load, da_is_store, da_illegal},
             {m.wb, m.br, m.jmp, m.ld, m.st, m.ill});
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, da_valid, 0);
      chk({tag, "_pc"}, da_pc, 0);
      chk({tag, "_sels"}, {da_write_sel, da_read_sel1, da_read_sel2}, 0);
      chk({tag, "_data"}, {da_data1, da_data2}, 0);
      chk({tag, "_imm_tgt"}, {da_imm32, da_target_PC}, 0);
      chk({tag, "_alu_flags"}, {da_ALU_Control, da_is_wb, da_is_branch, da_is_jump,
                                da_is_load, da_is_store, da_illegal}, 0);
      chk({tag, "_cnt"}, d_stall_count, 0);
      chk({tag, "_fd_ready"}, fd_ready, 1);
   endtask

   // one clock: check ready against the model, advance the model, check outputs
   task automatic step();
      exp_t nd;
      logic u1, u2, adv, haz;
      #1;
      nd    = ref_dec(fd_instr, fd_pc, u1, u2);
      nd.d1 = rdreg(fd_instr[19:15]);
      nd.d2 = rdreg(fd_instr[24:20]);
      adv   = !m.valid || a_ready;
      haz   = fd_valid && m.valid && m.ld && m.wsel != 0 &&
              ((u1 && nd.rs1 == m.wsel) || (u2 && nd.rs2 == m.wsel));
      chk("fd_ready", fd_ready, adv && (!haz || flush));
      @(posedge clock);
      if (flush) m.valid = 0;
      else if (adv && haz) begin
         m.valid = 0;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      end else if (adv && fd_valid) m = nd;
      else if (adv) m.valid = 0;
      if (w_regfile && sel_regfile != 0) regs[sel_regfile] = data_regfile;
      #1;
      check_outputs();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      logic [6:0]  opcs [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h7F, 7'h17};
      ins = $urandom;
      ins[6:0] = opcs[$urandom_range(0, 8)];
      if ($urandom_range(0, 3) != 0) begin
         ins[11:7]  = 5'($urandom_range(0, 3));
         ins[19:15] = 5'($urandom_range(0, 3));
         ins[24:20] = 5'($urandom_range(0, 3));
      end
      return ins;
   endfunction

   task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
      fd_valid = 1; fd_instr = ins; fd_pc = pc;
      step();
   endtask

   initial begin
      logic [31:0] held_pc;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_zero("reset");
      @(negedge clock);
      reset = 1;

      a_ready = 1;
      issue(32'hFFD00293, 32'h100);              // addi x5,x0,-3
      chk("addi_valid", da_valid, 1);
      chk("addi_imm", da_imm32, 32'hFFFFFFFD);
      chk("addi_rd", da_write_sel, 5);
      chk("addi_wb", da_is_wb, 1);
      chk("addi_alu", da_ALU_Control, 6'b000000);

      issue(32'h0000A303, 32'h104);              // lw x6,0(x1)
      chk("lw_load", da_is_load, 1);
      issue(32'h002303B3, 32'h108);              // add x7,x6,x2 -> bubble
      chk("bubble_valid", da_valid, 0);
      chk("bubble_cnt", d_stall_count, 1);
      step();
      chk("add_issued", da_valid, 1);
      chk("add_rd", da_write_sel, 7);

      w_regfile = 1; sel_regfile = 3; data_regfile = 32'hDEADBEEF;
      issue(32'h00318233, 32'h10C);              // add x4,x3,x3 with bypass
      chk("bypass_d1", da_data1, 32'hDEADBEEF);
      chk("bypass_d2", da_data2, 32'hDEADBEEF);
      w_regfile = 0;

      issue(32'h02000063, 32'hFFFFFFF0);         // beq x0,x0,+0x20
      chk("beq_target", da_target_PC, 32'h00000010);
      chk("beq_alu", da_ALU_Control, 6'b010000);

      held_pc = da_pc;
      a_ready = 0;
      for (int i = 0; i < 3; i++) begin
         issue(32'h00100093, 32'h200);
         chk("hold_pc", da_pc, held_pc);
         chk("hold_valid", da_valid, 1);
      end
      flush = 1;
      step();
      chk("flush_valid", da_valid, 0);
      flush = 0; a_ready = 1;

      issue(32'h000002FF, 32'h300);              // opcode 0x7F, rd=5
      chk("illegal_flag", da_illegal, 1);
      chk("illegal_wb", da_is_wb, 0);

      for (int i = 0; i < 600; i++) begin
         fd_valid     = ($urandom_range(0, 3) != 0);
         fd_instr     = rand_instr();
         fd_pc        = $urandom;
         flush        = ($urandom_range(0, 15) == 0);
         w_regfile    = 1'($urandom_range(0, 1));
         sel_regfile  = 5'($urandom_range(0, 3));
         data_regfile = $urandom;
         a_ready      = ($urandom_range(0, 9) < 7);
         step();
      end
      flush = 0; w_regfile = 0; a_ready = 1;

      issue(32'h0000A303, 32'h400);              // lw x6, then stall with ALU busy
      a_ready = 0;
      issue(32'h002303B3, 32'h404);
      chk("prereset_valid", da_valid, 1);
      #2;
      reset = 0;
      #1;
      model_reset();
      check_zero("async_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
